// File: rtl/inv_permute_unit_pkg.sv
// Shared constants for the Keccak rho+pi permute stage: lane geometry, the rotation
// table, the inverse source-lane map and the controller state encoding.
package inv_permute_unit_pkg;

    localparam int LANE_W     = 64;
    localparam int LANES      = 25;
    localparam int LANE_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REL = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Indexed by destination lane i = x + 5y: source lane y + 5*((2x+3y) mod 5).
    localparam logic [4:0] SRC_LANE [LANES] = '{
        5'd0,  5'd10, 5'd20, 5'd5,  5'd15,
        5'd16, 5'd1,  5'd11, 5'd21, 5'd6,
        5'd7,  5'd17, 5'd2,  5'd12, 5'd22,
        5'd23, 5'd8,  5'd18, 5'd3,  5'd13,
        5'd14, 5'd24, 5'd9,  5'd19, 5'd4
    };

    // Rho offsets R[x][y], indexed by lane i = x + 5y.
    localparam logic [5:0] ROT_R [LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

endpackage

// File: rtl/inv_permute_unit_if.sv
// Control handshake and memory ports of the inverse permute unit.
interface inv_permute_unit_if #(
    parameter int LANE_W = 64,
    parameter int ADDR_W = 11
);
    import inv_permute_unit_pkg::*;

    // start is a level request: the run begins the cycle after start falls, busy covers
    // the run and ready pulses for one cycle at the end. rd_data belongs to the rd_en of
    // the previous cycle; a write is taken in every cycle wr_en is high.
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [LANE_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANE_W-1:0] wr_data;
    logic              busy;
    logic              ready;
    state_e            dbg_state;

    modport slave (
        input  start, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, ready, dbg_state
    );

    modport master (
        output start, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, ready, dbg_state
    );

endinterface

// File: rtl/inv_permute_unit_ctrl.sv
// Sequencer for the inverse permute: waits for start release, walks block/lane
// counters one lane per clock, then drains the write pipeline and pulses ready.
module inv_permute_ctrl
    import inv_permute_unit_pkg::*;
#(
    parameter int NUM_BLOCKS = 64,
    parameter int BLK_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic                  busy,
    output logic                  ready,
    output logic [BLK_W-1:0]      blk_cnt,
    output logic [LANE_IDX_W-1:0] lane_cnt,
    output state_e                state
);

    state_e state_nxt;
    logic   lane_last;
    logic   blk_last;

    assign lane_last = (lane_cnt == LANE_IDX_W'(LANES - 1));
    assign blk_last  = (blk_cnt == BLK_W'(NUM_BLOCKS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_WAIT_REL;
            ST_WAIT_REL: if (!start) state_nxt = ST_RUN;
            ST_RUN:      if (lane_last && blk_last) state_nxt = ST_DRAIN;
            ST_DRAIN:    state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // The block counter holds at its last value on the final lane so it never overruns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_cnt  <= '0;
            lane_cnt <= '0;
        end else if (state == ST_WAIT_REL) begin
            blk_cnt  <= '0;
            lane_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (lane_last) begin
                lane_cnt <= '0;
                if (!blk_last) blk_cnt <= blk_cnt + 1'b1;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        ready = 1'b0;
        case (state)
            ST_WAIT_REL: busy = 1'b1;
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            ST_DRAIN:    busy = 1'b1;
            ST_DONE:     ready = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: rtl/inv_permute_unit.sv
// Inverse rho+pi: each destination lane is read from its remapped source lane and
// rotated right by the rho offset, one lane per clock with a one-stage write pipeline.
module inv_permute_unit #(
    parameter int LANE_W     = inv_permute_unit_pkg::LANE_W,
    parameter int NUM_BLOCKS = 64,
    parameter int ADDR_W     = 11
) (
    input logic              clk,
    input logic              rst,
    inv_permute_unit_if.slave bus
);
    import inv_permute_unit_pkg::*;

    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic [BLK_W-1:0]      blk_cnt;
    logic [LANE_IDX_W-1:0] lane_cnt;
    logic                  rd_en;
    logic [ADDR_W-1:0]     blk_base;

    logic                  wr_en_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [LANE_IDX_W-1:0] rot_idx_q;
    int                    rot_amt;

    inv_permute_ctrl #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLK_W      (BLK_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (bus.start),
        .rd_en    (rd_en),
        .busy     (bus.busy),
        .ready    (bus.ready),
        .blk_cnt  (blk_cnt),
        .lane_cnt (lane_cnt),
        .state    (bus.dbg_state)
    );

    assign blk_base    = ADDR_W'(blk_cnt) * ADDR_W'(LANES);
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_en ? (blk_base + ADDR_W'(SRC_LANE[lane_cnt])) : '0;

    // Destination address and rotation index travel with the read so they line up
    // with rd_data one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rot_idx_q <= '0;
        end else begin
            wr_en_q <= rd_en;
            if (rd_en) begin
                wr_addr_q <= blk_base + ADDR_W'(lane_cnt);
                rot_idx_q <= lane_cnt;
            end
        end
    end

    // A shift by LANE_W yields zero, so a zero offset passes the lane through unchanged.
    assign rot_amt     = int'(ROT_R[rot_idx_q]) % LANE_W;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_en_q ? wr_addr_q : '0;
    assign bus.wr_data = wr_en_q ? ((bus.rd_data >> rot_amt) | (bus.rd_data << (LANE_W - rot_amt)))
                                 : '0;

endmodule

// File: doc/inv_permute_unit.md
Name: inv_permute_unit

Overview:
- Decoder-side inverse of the encoder's permute stage. It undoes Keccak rho+pi on a lane-organised state held in external synchronous memory.
- Each 25-lane block (5x5 lanes of 64 bits) is read lane by lane. Every output lane is built from its remapped source lane, rotated right, and written to a destination memory.
- It processes NUM_BLOCKS consecutive blocks per start and signals completion with a one-cycle ready pulse. Its start/ready handshake is the one the encoder controllers use.

Parameters:
- LANE_W, 64, lane width in bits; rotation offsets are taken mod LANE_W.
- NUM_BLOCKS, 64, blocks processed per start.
- ADDR_W, 11, memory address width; must satisfy 2^ADDR_W >= NUM_BLOCKS*25.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- start  input  1  request; the run begins on the cycle after start falls.
- rd_en  output  1  source memory read strobe.
- rd_addr  output  ADDR_W  source lane address.
- rd_data  input  LANE_W  source data, valid the cycle after rd_en (1-cycle synchronous read).
- wr_en  output  1  destination write strobe.
- wr_addr  output  ADDR_W  destination lane address.
- wr_data  output  LANE_W  destination lane data.
- busy  output  1  high from start acceptance until the ready pulse.
- ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all counters 0; rd_en, wr_en, busy and ready all 0; addresses and wr_data 0. Reset mid-run aborts immediately and no further writes occur.
- Lane index i = x + 5y, with x, y in 0..4. The block base is b*25, b in 0..NUM_BLOCKS-1.
- Inverse mapping: out lane (x,y) = rotr(src lane (y, (2x+3y) mod 5), R[x][y]).
  - Source lane index = y + 5*((2x+3y) mod 5).
  - rd_addr = b*25 + src(i); wr_addr = b*25 + i.
- Rotation table R[x][y], rows listed as y=0..4, each row x=0..4:
  - y=0: 0 1 62 28 27
  - y=1: 36 44 6 55 20
  - y=2: 3 10 43 25 39
  - y=3: 41 45 15 21 8
  - y=4: 18 2 61 56 14
  - Rotation is a right rotate: wr_data = (d >> r) | (d << (LANE_W-r)), and r=0 passes data unchanged.
- FSM:
  - IDLE: start=1 -> WAIT_REL.
  - WAIT_REL: busy=1; clear the block and lane counters; start=0 -> RUN, otherwise stay.
  - RUN: rd_en=1 with rd_addr for (b,i). Advance i; when i=24, wrap i to 0 and increment b. After the read for (NUM_BLOCKS-1, 24) -> DRAIN.
  - DRAIN: rd_en=0; the write for the final lane completes here -> DONE.
  - DONE: ready=1, busy=0 -> IDLE.
- Pipeline: a read issued in cycle t is written in cycle t+1. The lane's rotation index and wr_addr are registered alongside the read, so wr_en in cycle t+1 equals rd_en in cycle t. Throughput is 1 lane/clk with no gaps.
- Latency: exactly NUM_BLOCKS*25 RUN cycles. ready rises 2 cycles after the last RUN cycle (DRAIN, then DONE).
- start while busy is ignored. start held high keeps the FSM in WAIT_REL indefinitely, with no memory traffic.
- The lane counter wraps 24->0 only together with a block increment. The block counter never exceeds NUM_BLOCKS-1.
- Source and destination are distinct memories; in-place operation is not supported.

Decomposition:
- Shared package: LANE_W, the lanes-per-block constant 25, the R[x][y] rotation table, the src(i) index table, and the FSM state encoding. The encoder-side permute block uses the same tables.
- One natural sub-module: inv_permute_ctrl, containing the FSM, counters and strobes. The top holds the address map, the pipeline registers and the rotator.

Test Plan:
- start pulse 1 cycle then low, NUM_BLOCKS=1 -> 25 reads at rd_addr 0,10,20,5,15,16,... (src table order). ready pulses at the 27th cycle after the first RUN cycle; busy falls with the ready pulse.
- Source lane 10 = 64'h1 -> wr_addr 1 gets 64'h8000_0000_0000_0000 (rotr 1). Source lane 16 = 64'h1 -> wr_addr 5 gets 1<<28 (rotr 36). Lane 0 passes unchanged.
- Round trip: random 1600-lane state through a golden forward rho+pi, then this block (NUM_BLOCKS=64) -> output bit-exact to the original. Exactly 1600 wr_en cycles; the last wr_addr is 1599.
- start held high 10 cycles -> no rd_en during the hold. The first rd_en arrives 1 cycle after start falls.
- rst=0 asserted at lane 7 of block 3 -> next cycle rd_en=wr_en=busy=0. A fresh start restarts from address 0.
- start pulsed during RUN -> ignored: the write count is unchanged and ready pulses once.
